// File: rtl/elevator_dispatch_if.sv
// Call/clear handshake and car-status bundle between the call register file and the dispatcher.
// master = dispatcher side, slave = register file / observer side.
interface elevator_dispatch_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] call_mask;
    logic                  clr_valid;
    logic [FLOOR_W-1:0]    clr_floor;
    logic [FLOOR_W-1:0]    cur_floor;
    logic                  dir_up;
    logic                  moving;
    logic                  door_open;

    modport master (
        input  call_mask,
        output clr_valid, clr_floor, cur_floor, dir_up, moving, door_open
    );

    modport slave (
        output call_mask,
        input  clr_valid, clr_floor, cur_floor, dir_up, moving, door_open
    );
endinterface

// File: rtl/elevator_dispatch.sv
// Collective-SCAN elevator dispatcher: serves latched floor calls, models travel and door timing,
// and pulses a clear back to the call register file. Optional homing to floor 0 via `IDLE_HOME_EN.
module elevator_dispatch #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 32,
    parameter int IDLE_TIMEOUT  = 256
) (
    input  logic                clk,
    input  logic                reset,
    elevator_dispatch_if.master bus
);
    localparam int TW = (TRAVEL_CYCLES > 2) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = $clog2(DOOR_CYCLES);
    localparam bit CFG_OK = (TRAVEL_CYCLES >= 2) && (DOOR_CYCLES >= 3) && (IDLE_TIMEOUT >= 2)
                            && (NUM_FLOORS <= (1 << FLOOR_W));

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
    logic               dir_up_q, dir_up_d;
    logic               moving_q, door_open_q;
    logic               clr_valid_q, clr_valid_d;
    logic               clr_prev_q;
    logic [FLOOR_W-1:0] clr_floor_q, clr_floor_d;
    logic [TW-1:0]      travel_cnt_q, travel_cnt_d;
    logic [DW-1:0]      door_cnt_q, door_cnt_d;

    logic [NUM_FLOORS-1:0] above_v, below_v;
    logic here, above, below, ahead, behind;
    logic travel_term, door_term, recall;

    generate
        for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor_cmp
            assign above_v[gi] = bus.call_mask[gi] & (FLOOR_W'(gi) > cur_floor_q);
            assign below_v[gi] = bus.call_mask[gi] & (FLOOR_W'(gi) < cur_floor_q);
        end
    endgenerate

    assign here        = bus.call_mask[cur_floor_q];
    assign above       = |above_v;
    assign below       = |below_v;
    assign ahead       = dir_up_q ? above : below;
    assign behind      = dir_up_q ? below : above;
    assign travel_term = (travel_cnt_q == TW'(TRAVEL_CYCLES - 1));
    assign door_term   = (door_cnt_q == DW'(DOOR_CYCLES - 1));
    // Two-cycle lockout hides the register file's clear latency so one call gives one pulse.
    assign recall      = here && !clr_valid_q && !clr_prev_q;

`ifdef IDLE_HOME_EN
    localparam int IW = $clog2(IDLE_TIMEOUT);
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          homing_q, homing_d;
    logic          home_go;

    assign home_go = (bus.call_mask == '0) && (cur_floor_q != '0)
                     && (homing_q || (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d = ST_DOOR;
                end else if (ahead || behind) begin
                    state_d = ST_MOVING;
`ifdef IDLE_HOME_EN
                end else if (home_go) begin
                    state_d = ST_MOVING;
`endif
                end
            end
            ST_MOVING: if (travel_term) state_d = ST_IDLE;
            ST_DOOR:   if (!recall && door_term) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_floor_d  = cur_floor_q;
        dir_up_d     = dir_up_q;
        clr_valid_d  = 1'b0;
        clr_floor_d  = clr_floor_q;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;
`ifdef IDLE_HOME_EN
        idle_cnt_d   = '0;
        homing_d     = homing_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    clr_valid_d = 1'b1;
                    clr_floor_d = cur_floor_q;
                    door_cnt_d  = '0;
                end else if (ahead) begin
                    travel_cnt_d = '0;
                end else if (behind) begin
                    dir_up_d     = ~dir_up_q;
                    travel_cnt_d = '0;
`ifdef IDLE_HOME_EN
                end else if (home_go) begin
                    dir_up_d     = 1'b0;
                    travel_cnt_d = '0;
`endif
                end
`ifdef IDLE_HOME_EN
                // Saturating count; homing latches until a call appears or floor 0 is reached.
                if (bus.call_mask == '0) begin
                    idle_cnt_d = (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) ? idle_cnt_q : idle_cnt_q + 1'b1;
                end
                homing_d = home_go;
`endif
            end
            ST_MOVING: begin
                if (travel_term) begin
                    travel_cnt_d = '0;
                    cur_floor_d  = dir_up_q ? cur_floor_q + 1'b1 : cur_floor_q - 1'b1;
                end else begin
                    travel_cnt_d = travel_cnt_q + 1'b1;
                end
            end
            ST_DOOR: begin
                if (recall) begin
                    clr_valid_d = 1'b1;
                    clr_floor_d = cur_floor_q;
                    door_cnt_d  = '0;
                end else if (door_term) begin
                    door_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_floor_q  <= '0;
            dir_up_q     <= 1'b1;
            moving_q     <= 1'b0;
            door_open_q  <= 1'b0;
            clr_valid_q  <= 1'b0;
            clr_prev_q   <= 1'b0;
            clr_floor_q  <= '0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            cur_floor_q  <= cur_floor_d;
            dir_up_q     <= dir_up_d;
            moving_q     <= (state_d == ST_MOVING);
            door_open_q  <= (state_d == ST_DOOR);
            clr_valid_q  <= clr_valid_d;
            clr_prev_q   <= clr_valid_q;
            clr_floor_q  <= clr_floor_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
        end
    end

`ifdef IDLE_HOME_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt_q <= '0;
            homing_q   <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            homing_q   <= homing_d;
        end
    end
`endif

    assign bus.cur_floor = cur_floor_q;
    assign bus.dir_up    = dir_up_q;
    assign bus.moving    = moving_q;
    assign bus.door_open = door_open_q;
    assign bus.clr_valid = clr_valid_q;
    assign bus.clr_floor = clr_floor_q;

    a_cfg_ok: assert property (@(posedge clk) CFG_OK);

    a_no_wrap: assert property (@(posedge clk) disable iff (!reset)
        (state_q == ST_MOVING && travel_term) |->
            (dir_up_q ? (cur_floor_q != FLOOR_W'(NUM_FLOORS - 1)) : (cur_floor_q != '0)));

    a_clr_single: assert property (@(posedge clk) disable iff (!reset)
        clr_valid_q |=> !clr_valid_q);
endmodule

// File: tb/tb_elevator_dispatch.sv
// Directed bench for elevator_dispatch: a small call-register model feeds call_mask, and a
// scoreboard queue holds the floor of every clear pulse the car is expected to issue, in order.
module tb_elevator_dispatch;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] raise = '0;
    logic [7:0] call_q;
    logic [7:0] clr_vec;
    int         checks = 0;
    int         errors = 0;
    int         clr_count = 0;
    logic       prev_clr = 1'b0;
    int         exp_q[$];

    always #5 clk = ~clk;

    elevator_dispatch_if #(.NUM_FLOORS(8), .FLOOR_W(3)) bus ();

    elevator_dispatch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Call register file model: new calls OR in, a clear pulse drops its bit on the next edge.
    assign clr_vec = bus.clr_valid ? (8'd1 << bus.clr_floor) : 8'd0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) call_q <= '0;
        else        call_q <= (call_q & ~clr_vec) | raise;
    end
    assign bus.call_mask = call_q;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.clr_valid) begin
            clr_count++;
            check("clr_consecutive", 32'(prev_clr), 32'd0);
            if (exp_q.size() == 0) begin
                check("clr_unexpected", 32'(bus.clr_floor), 32'hFFFF_FFFF);
            end else begin
                int e;
                e = exp_q.pop_front();
                check("clr_floor", 32'(bus.clr_floor), 32'(e));
                $display("clr pulse: floor %0d (expected %0d) at %0t", bus.clr_floor, e, $time);
            end
        end
        prev_clr = bus.clr_valid;
    end

    task automatic raise_calls(input logic [7:0] m);
        raise = m;
        @(negedge clk);
        raise = '0;
    endtask

    task automatic wait_door_rise();
        int n = 0;
        while (!bus.door_open && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check("door_rise_timeout", 32'(bus.door_open), 32'd1);
    endtask

    task automatic count_door(output int n);
        n = 0;
        while (bus.door_open && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic serve_one();
        int n;
        wait_door_rise();
        count_door(n);
        check("door_fall_timeout", 32'(bus.door_open), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        repeat (3) @(negedge clk);
        check("rst_cur_floor", 32'(bus.cur_floor), 32'd0);
        check("rst_dir_up", 32'(bus.dir_up), 32'd1);
        check("rst_moving", 32'(bus.moving), 32'd0);
        check("rst_door_open", 32'(bus.door_open), 32'd0);
        check("rst_clr_valid", 32'(bus.clr_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 1: call at the current floor opens the door for DOOR_CYCLES
        exp_q.push_back(0);
        raise_calls(8'h01);
        @(negedge clk);
        check("t1_door_open", 32'(bus.door_open), 32'd1);
        check("t1_clr_valid", 32'(bus.clr_valid), 32'd1);
        count_door(n);
        check("t1_door_cycles", 32'(n), 32'd32);
        $display("t1: door open %0d cycles", n);

        // 2: five-floor trip up, one leg per floor, then a single clear at floor 5
        exp_q.push_back(5);
        raise_calls(8'h20);
        @(negedge clk);
        check("t2_dir_up", 32'(bus.dir_up), 32'd1);
        for (int leg = 0; leg < 5; leg++) begin
            n = 0;
            while (bus.moving && n < 100) begin
                n++;
                @(negedge clk);
            end
            check("t2_leg_cycles", 32'(n), 32'd16);
            check("t2_leg_floor", 32'(bus.cur_floor), 32'(leg + 1));
            @(negedge clk);
        end
        check("t2_door_open", 32'(bus.door_open), 32'd1);
        count_door(n);
        check("t2_door_cycles", 32'(n), 32'd32);

        // Position the car at floor 3 travelling up: go to 0, then to 3
        exp_q.push_back(0);
        raise_calls(8'h01);
        serve_one();
        exp_q.push_back(3);
        raise_calls(8'h08);
        serve_one();
        check("pos_floor3", 32'(bus.cur_floor), 32'd3);
        check("pos_dir_up", 32'(bus.dir_up), 32'd1);

        // 3: SCAN order 7 then 1, exactly two pulses
        base = clr_count;
        exp_q.push_back(7);
        exp_q.push_back(1);
        raise_calls(8'h82);
        serve_one();
        check("t3_first_floor", 32'(bus.cur_floor), 32'd7);
        serve_one();
        check("t3_second_floor", 32'(bus.cur_floor), 32'd1);
        check("t3_dir_down", 32'(bus.dir_up), 32'd0);
        check("t3_pulses", 32'(clr_count - base), 32'd2);

        // 4: re-call at the open floor restarts the door at door cycle 20
        exp_q.push_back(2);
        raise_calls(8'h04);
        wait_door_rise();
        repeat (18) @(negedge clk);
        exp_q.push_back(2);
        raise_calls(8'h04);
        count_door(n);
        check("t4_door_total", 32'(19 + n), 32'd52);
        $display("t4: door open %0d cycles in total", 19 + n);

        // 5: reset asserted mid-move
        base = clr_count;
        raise_calls(8'h20);
        @(negedge clk);
        check("t5_moving", 32'(bus.moving), 32'd1);
        repeat (40) @(negedge clk);
        check("t5_pre_floor", 32'(bus.cur_floor), 32'd4);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_floor", 32'(bus.cur_floor), 32'd0);
        check("t5_rst_moving", 32'(bus.moving), 32'd0);
        check("t5_rst_dir", 32'(bus.dir_up), 32'd1);
        check("t5_rst_door", 32'(bus.door_open), 32'd0);
        check("t5_rst_clr", 32'(bus.clr_valid), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_idle_floor", 32'(bus.cur_floor), 32'd0);
        check("t5_idle_moving", 32'(bus.moving), 32'd0);
        check("t5_no_clr", 32'(clr_count - base), 32'd0);

        // 6: park at floor 4 with no calls
        exp_q.push_back(4);
        raise_calls(8'h10);
        serve_one();
        check("t6_floor4", 32'(bus.cur_floor), 32'd4);
        base = clr_count;
        repeat (250) @(negedge clk);
        check("t6_still_parked", 32'(bus.cur_floor), 32'd4);
        check("t6_not_moving", 32'(bus.moving), 32'd0);
`ifdef IDLE_HOME_EN
        n = 0;
        while (!(bus.cur_floor == 3'd0 && !bus.moving) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("t6_homed_floor", 32'(bus.cur_floor), 32'd0);
        check("t6_homed_dir", 32'(bus.dir_up), 32'd0);
        $display("t6: homed to floor 0 after %0d further cycles", n);
`else
        repeat (150) @(negedge clk);
        check("t6_parked_floor", 32'(bus.cur_floor), 32'd4);
        check("t6_parked_moving", 32'(bus.moving), 32'd0);
`endif
        check("t6_no_clr", 32'(clr_count - base), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
